cla32_serial: RTL and testbench
===============================

# cla32_serial

Nibble-serial multi-word adder sitting directly upstream of the `cla4` 4-bit carry-lookahead adder. It owns the only `cla4` instance and feeds it one 4-bit slice of the latched operands per clock. It captures the slice sum and ripples the carry through a register, assembling a WIDTH-bit sum plus carry-out. A start/busy/done handshake trades latency for the area of a single `cla4`.

## Interface
- WIDTH, 32, operand/sum width in bits; must be a multiple of 4, minimum 4
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while busy=0
- a  input  WIDTH  operand A; latched on the accepting edge
- b  input  WIDTH  operand B; latched on the accepting edge
- ci  input  1  carry-in; latched on the accepting edge
- busy  output  1  high while slices are being added
- done  output  1  one-cycle pulse; s/co valid
- s  output  WIDTH  sum register
- co  output  1  final carry-out register

## Operation
- Reset: one clock, one synchronous active-high reset. Reset clears state to IDLE, busy=0, done=0, s=0, co=0, slice counter=0, carry register=0.
- N = WIDTH/4 slices. The slice counter has width clog2(N), min 1.
- States and transitions:
  - IDLE: busy=0, done=0. On start=1, latch a, b, ci; clear s and co; set cnt=0; go to RUN.
  - RUN: busy=1. `cla4` receives a[4·cnt+:4], b[4·cnt+:4], and the carry register (ci for cnt=0).
    - Each edge writes the slice sum into s[4·cnt+:4], loads the carry register from `cla4` co, and increments cnt.
    - At cnt=N-1, also load co and go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. On start=1, accept a new operation as from IDLE and go to RUN. Otherwise go to IDLE.
- start while busy=1 is ignored. There is no queuing.
- a, b, ci may change freely after the accepting edge without affecting the result.
- s and co hold their values after DONE until the next accepting edge clears them.
- Result is (a + b + ci) mod 2^WIDTH, with co = bit WIDTH of the full sum.
- reset asserted mid-RUN aborts the operation. All outputs return to reset values on that edge, and no done pulse is produced.

## Timing
- Latency: done is high in the cycle following the Nth edge after the accepting edge (N=8 for WIDTH=32).
- Throughput: one operation per N+1 cycles back-to-back. A start during DONE is accepted, so there is no idle gap.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- The combinational path per cycle is one `cla4` plus the slice mux.

## Configuration
- CLA32_SERIAL_OVF_EN defined:
  - Adds output `ovf` (1 bit, registered) = (a_msb == b_msb) && (s_msb != a_msb), using the latched operands. This is signed two's-complement overflow.
  - ovf is loaded together with co on the final RUN edge and cleared on reset and on accept.
- CLA32_SERIAL_OVF_EN undefined: the `ovf` port and its logic are absent. Port list and behaviour are otherwise identical.

## Structure
- Shared package `cla_pkg`:
  - state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10)
  - slice width constant SLICE_W=4
- Exactly one sub-module: the existing `cla4` (ports a, b, ci, s, co), instantiated once as U0_cla4.
- Operand registers, slice mux, counter, FSM, and result registers are inline in `cla32_serial`.

## Test plan
- Assert reset for 2 cycles with start=1 held high → busy=0, done=0, s=0, co=0 throughout reset, and no operation is accepted.
- a=0x0000000A, b=0x00000006, ci=1, start pulse → done after 8 cycles; s=0x00000011, co=0.
- a=0xFFFFFFFF, b=0x00000001, ci=0 → s=0x00000000, co=1. With CLA32_SERIAL_OVF_EN, ovf=0.
- a=0x7FFFFFFF, b=0x00000001, ci=0 with CLA32_SERIAL_OVF_EN → s=0x80000000, co=0, ovf=1.
- Start 0x5+0xA, then pulse start with different operands at cycle 3 of RUN → second start is ignored; s=0x0000000F, co=0, one done pulse only.
- Start 0xFFFFFFFF+0x1; assert reset at cycle 4 of RUN → all outputs 0 on the next edge and no done pulse. A start after reset deasserts with a=0x12345678, b=0x11111111, ci=0 → s=0x23456789, co=0.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encodings and slice width.
package cla_pkg;

  localparam int SLICE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder; all carries are formed directly from generate/propagate terms.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

  assign s  = w_p ^ w_c[3:0];
  assign co = w_c[4];

endmodule

// File: rtl/cla32_serial.sv
// Nibble-serial WIDTH-bit adder built around a single cla4, one slice per clock.
// Optional signed-overflow output enabled by defining CLA32_SERIAL_OVF_EN.
module cla32_serial
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef CLA32_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_c;
  logic [CNT_W-1:0]   r_cnt;

  logic [SLICE_W-1:0] w_a_sl;
  logic [SLICE_W-1:0] w_b_sl;
  logic [SLICE_W-1:0] w_s;
  logic               w_co;
  logic               w_accept;

  // The carry register is seeded with ci on accept, so slice 0 sees ci directly.
  assign w_a_sl = r_a[r_cnt*SLICE_W +: SLICE_W];
  assign w_b_sl = r_b[r_cnt*SLICE_W +: SLICE_W];

  cla4 U0_cla4 (
    .a  (w_a_sl),
    .b  (w_b_sl),
    .ci (r_c),
    .s  (w_s),
    .co (w_co)
  );

  assign busy     = (r_state == ST_RUN);
  assign done     = (r_state == ST_DONE);
  assign w_accept = start && (r_state != ST_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      s       <= '0;
      co      <= 1'b0;
`ifdef CLA32_SERIAL_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= ci;
            r_cnt   <= '0;
            s       <= '0;
            co      <= 1'b0;
`ifdef CLA32_SERIAL_OVF_EN
            ovf     <= 1'b0;
`endif
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          s[r_cnt*SLICE_W +: SLICE_W] <= w_s;
          r_c   <= w_co;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            co      <= w_co;
`ifdef CLA32_SERIAL_OVF_EN
            // w_s[SLICE_W-1] is the final sum MSB on the last slice.
            ovf     <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[SLICE_W-1] != r_a[WIDTH-1]);
`endif
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla32_serial.sv
// Directed bench for cla32_serial: vector table plus multi-cycle handshake/reset sequences.
module tb_cla32_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;
  logic        busy;
  logic        done;
  logic [31:0] s;
  logic        co;
`ifdef CLA32_SERIAL_OVF_EN
  logic        ovf;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cla32_serial #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co)
`ifdef CLA32_SERIAL_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] es;
    logic        eco;
    logic        eovf;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Entered and left at a negedge. Drives one start pulse, then scrambles inputs.
  task automatic exec(input vec_t v);
    int lat;
    a = v.a; b = v.b; ci = v.ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~v.a; b = $urandom; ci = ~v.ci;
    chk("accept_state", {busy, done, co, s}, {1'b1, 1'b0, 1'b0, 32'h0});
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 9);
    chk("sum", s, v.es);
    chk("carry_out", co, v.eco);
`ifdef CLA32_SERIAL_OVF_EN
    chk("ovf", ovf, v.eovf);
`endif
    @(negedge clk);
    chk("done_one_cycle", {busy, done}, 2'b00);
    chk("sum_hold", s, v.es);
  endtask

  initial begin
    int ndone;
    logic [31:0] s_at_done;
    vec_t v;

    tbl[0] = '{32'h0000000A, 32'h00000006, 1'b1, 32'h00000011, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[3] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    tbl[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    tbl[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    tbl[6] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[7] = '{32'hDEADBEEF, 32'h21524110, 1'b1, 32'h00000000, 1'b1, 1'b0};

    // Reset held two cycles with start high: nothing may be accepted.
    reset = 1'b1; start = 1'b1; a = 32'h1; b = 32'h2; ci = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_outputs", {busy, done, co, s}, 34'h0);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy, done, co, s}, 34'h0);

    for (int i = 0; i < 8; i++) exec(tbl[i]);

    // Start during RUN is ignored; exactly one done pulse.
    a = 32'h5; b = 32'hA; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; ci = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; s_at_done = '0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin ndone++; s_at_done = s; end
      @(negedge clk);
    end
    chk("ignored_start_pulses", ndone, 1);
    chk("ignored_start_sum", s_at_done, 32'h0000000F);
    chk("ignored_start_co", co, 1'b0);

    // Back-to-back: a start during DONE is accepted with no idle gap.
    a = 32'h00000003; b = 32'h00000004; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    while (!done && ndone < 20) begin @(negedge clk); ndone++; end
    chk("b2b_first_sum", s, 32'h00000007);
    a = 32'h0000FFFF; b = 32'h00000001; ci = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accept", {busy, done, s}, {1'b1, 1'b0, 32'h0});
    ndone = 1;
    while (!done && ndone < 20) begin @(negedge clk); ndone++; end
    chk("b2b_latency", ndone, 9);
    chk("b2b_second_sum", s, 32'h00010001);
    @(negedge clk);

    // Reset in the middle of RUN aborts with no done pulse.
    a = 32'hFFFFFFFF; b = 32'h00000001; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("midrun_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrun_reset_outputs", {busy, done, co, s}, 34'h0);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrun_no_done", ndone, 0);
    v = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    exec(v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
